// File: rtl/mcp_pkg.sv
// Shared encodings for the multicycle main control unit.
package mcp_pkg;

    localparam int unsigned OP_W    = 6;
    localparam int unsigned FN_W    = 6;
    localparam int unsigned STATE_W = 4;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;

    localparam logic [FN_W-1:0] FN_ADD = 6'b100000;
    localparam logic [FN_W-1:0] FN_SUB = 6'b100010;
    localparam logic [FN_W-1:0] FN_AND = 6'b100100;
    localparam logic [FN_W-1:0] FN_OR  = 6'b100101;
    localparam logic [FN_W-1:0] FN_SLT = 6'b101010;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mcp_controller_if.sv
// Control-unit <-> datapath bundle: instruction fields and flags in, selects and enables out.
interface mcp_controller_if #(
    parameter int unsigned OPW = 6,
    parameter int unsigned FNW = 6
);
    logic [OPW-1:0] op;
    logic [FNW-1:0] funct;
    logic           zero;
    logic           mem_ready;

    logic           iord;
    logic           mem_write;
    logic           ir_write;
    logic           reg_dst;
    logic           mem_to_reg;
    logic           reg_write;
    logic           alu_src_a;
    logic [1:0]     alu_src_b;
    logic [1:0]     pc_src;
    logic           pc_en;
    logic [2:0]     alu_control;
    logic           illegal_op;
    logic [3:0]     state;

    modport ctrl (
        input  op, funct, zero, mem_ready,
        output iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
               alu_src_a, alu_src_b, pc_src, pc_en, alu_control, illegal_op, state
    );

    modport dp (
        output op, funct, zero, mem_ready,
        input  iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
               alu_src_a, alu_src_b, pc_src, pc_en, alu_control, illegal_op, state
    );
endinterface

// File: rtl/alu_decoder.sv
// Maps aluop plus funct to the ALU operation; unknown funct falls back to add.
module alu_decoder
    import mcp_pkg::*;
#(
    parameter int unsigned FNW = 6
) (
    input  aluop_t         aluop,
    input  logic [FNW-1:0] funct,
    output logic [2:0]     alu_control,
    output logic           funct_illegal
);

    // Operation select; funct only matters for R-type execution.
    always_comb begin
        alu_control   = ALU_ADD;
        funct_illegal = 1'b0;
        case (aluop)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                if      (funct == FNW'(FN_ADD)) alu_control = ALU_ADD;
                else if (funct == FNW'(FN_SUB)) alu_control = ALU_SUB;
                else if (funct == FNW'(FN_AND)) alu_control = ALU_AND;
                else if (funct == FNW'(FN_OR))  alu_control = ALU_OR;
                else if (funct == FNW'(FN_SLT)) alu_control = ALU_SLT;
                else begin
                    alu_control   = ALU_ADD;
                    funct_illegal = 1'b1;
                end
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mcp_controller.sv
// Multicycle main control: Moore sequencer driving datapath selects and write enables.
module mcp_controller
    import mcp_pkg::*;
#(
    parameter int unsigned OPW = 6,
    parameter int unsigned FNW = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    mcp_controller_if.ctrl bus
);

    state_t state_q;
    state_t state_d;
    aluop_t aluop;
    logic   pc_write;
    logic   branch;
    logic   funct_illegal;
    logic   op_legal;

    assign op_legal = (bus.op == OPW'(OP_LW))   || (bus.op == OPW'(OP_SW))  ||
                      (bus.op == OPW'(OP_RTYPE)) || (bus.op == OPW'(OP_BEQ)) ||
                      (bus.op == OPW'(OP_ADDI))  || (bus.op == OPW'(OP_J));

    // State register; reset wins from any state, including a stalled store.
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    // Next-state sequencing; memory steps hold until mem_ready.
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:   state_d = bus.mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if ((bus.op == OPW'(OP_LW)) || (bus.op == OPW'(OP_SW))) state_d = S_MEMADR;
                else if (bus.op == OPW'(OP_RTYPE)) state_d = S_EXECUTE;
                else if (bus.op == OPW'(OP_BEQ))   state_d = S_BRANCH;
                else if (bus.op == OPW'(OP_ADDI))  state_d = S_ADDIEX;
                else if (bus.op == OPW'(OP_J))     state_d = S_JUMP;
                else                               state_d = S_FETCH;
            end
            S_MEMADR:  state_d = (bus.op == OPW'(OP_LW)) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   state_d = bus.mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:   state_d = bus.mem_ready ? S_FETCH : S_MEMWR;
            S_EXECUTE: state_d = S_ALUWB;
            S_ADDIEX:  state_d = S_ADDIWB;
            default:   state_d = S_FETCH;
        endcase
    end

    // Per-state control decode; only fetch looks at mem_ready.
    always_comb begin
        bus.iord       = 1'b0;
        bus.mem_write  = 1'b0;
        bus.ir_write   = 1'b0;
        bus.reg_dst    = 1'b0;
        bus.mem_to_reg = 1'b0;
        bus.reg_write  = 1'b0;
        bus.alu_src_a  = 1'b0;
        bus.alu_src_b  = SRCB_B;
        bus.pc_src     = PCSRC_ALU;
        aluop          = ALUOP_ADD;
        pc_write       = 1'b0;
        branch         = 1'b0;
        case (state_q)
            S_FETCH: begin
                bus.alu_src_b = SRCB_FOUR;
                bus.ir_write  = bus.mem_ready;
                pc_write      = bus.mem_ready;
            end
            S_DECODE: bus.alu_src_b = SRCB_IMM_SH;
            S_MEMADR, S_ADDIEX: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = SRCB_IMM;
            end
            S_MEMRD: bus.iord = 1'b1;
            S_MEMWR: begin
                bus.iord      = 1'b1;
                bus.mem_write = 1'b1;
            end
            S_MEMWB: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = 1'b1;
            end
            S_EXECUTE: begin
                bus.alu_src_a = 1'b1;
                aluop         = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                bus.reg_write = 1'b1;
                bus.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                bus.alu_src_a = 1'b1;
                aluop         = ALUOP_SUB;
                branch        = 1'b1;
                bus.pc_src    = PCSRC_ALUOUT;
            end
            S_ADDIWB: bus.reg_write = 1'b1;
            S_JUMP: begin
                pc_write   = 1'b1;
                bus.pc_src = PCSRC_JUMP;
            end
            default: ;
        endcase
    end

    alu_decoder #(.FNW(FNW)) u_alu_decoder (
        .aluop         (aluop),
        .funct         (bus.funct),
        .alu_control   (bus.alu_control),
        .funct_illegal (funct_illegal)
    );

    assign bus.pc_en      = pc_write | (branch & bus.zero);
    assign bus.illegal_op = ((state_q == S_DECODE) && !op_legal) ||
                            ((state_q == S_EXECUTE) && funct_illegal);
    assign bus.state      = STATE_W'(state_q);

endmodule
